// File: rtl/keypad_control.sv
// keypad_control: scans a 4x4 active-low keypad, debounces presses and
// maps accepted keys onto the oscillator / lowpass / highpass selects.
module keypad_control #(
  parameter int SCAN_DIV = 48,
  parameter int DEBOUNCE = 20
) (
  input  logic       clk_48,
  input  logic       reset_n,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  output logic [2:0] freqSelect,
  output logic [2:0] lowpassSelect,
  output logic [2:0] highpassSelect,
  output logic [1:0] edit_mode,
  output logic       key_valid,
  output logic [3:0] key_code
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [2:0] FREQ_RST = 3'd4;
  localparam logic [2:0] LP_RST = 3'd1;
  localparam logic [2:0] HP_RST = 3'd3;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    HELD
  } state_t;

  state_t        state;
  logic [3:0]    kpr_m;
  logic [3:0]    kpr_s;
  logic [DW-1:0] dwell;
  logic [CW-1:0] cnt;
  logic [1:0]    row_c;

  logic       sample;
  logic       single;
  logic       clear;
  logic       accept;
  logic [1:0] row_i;
  logic [1:0] col_i;
  logic [3:0] code;
  logic [3:0] kpc_next;

  assign sample   = (dwell == DWELL_LAST);
  assign clear    = (kpr_s == 4'hF);
  assign kpc_next = {kpc[2:0], kpc[3]};

  always_comb begin
    single = 1'b1;
    row_i  = 2'd0;
    case (kpr_s)
      4'b1110: row_i = 2'd0;
      4'b1101: row_i = 2'd1;
      4'b1011: row_i = 2'd2;
      4'b0111: row_i = 2'd3;
      default: single = 1'b0;
    endcase
  end

  always_comb begin
    col_i = 2'd0;
    case (kpc)
      4'b1110: col_i = 2'd0;
      4'b1101: col_i = 2'd1;
      4'b1011: col_i = 2'd2;
      4'b0111: col_i = 2'd3;
      default: col_i = 2'd0;
    endcase
  end

  // Letter column is A..D; bottom row is *,0,#; the rest are 1..9.
  always_comb begin
    code = 4'h0;
    if (col_i == 2'd3)
      code = 4'hA + {2'b00, row_i};
    else if (row_i == 2'd3)
      code = (col_i == 2'd0) ? 4'hE :
             (col_i == 2'd1) ? 4'h0 : 4'hF;
    else
      code = 4'(3 * row_i + col_i + 1);
  end

  assign accept = sample && single && (
    (state == SCAN && DEBOUNCE <= 1) ||
    (state == DEB_PRESS && row_i == row_c &&
     cnt == CNT_LAST));

  always_ff @(posedge clk_48) begin
    if (!reset_n) begin
      kpr_m          <= 4'hF;
      kpr_s          <= 4'hF;
      dwell          <= '0;
      cnt            <= '0;
      row_c          <= 2'd0;
      state          <= SCAN;
      kpc            <= 4'b1110;
      freqSelect     <= FREQ_RST;
      lowpassSelect  <= LP_RST;
      highpassSelect <= HP_RST;
      edit_mode      <= 2'd0;
      key_valid      <= 1'b0;
      key_code       <= 4'h0;
    end else begin
      kpr_m     <= kpr;
      kpr_s     <= kpr_m;
      dwell     <= sample ? '0 : dwell + 1'b1;
      key_valid <= accept;
      if (sample) begin
        case (state)
          SCAN: begin
            if (!single) begin
              kpc <= kpc_next;
            end else if (accept) begin
              state <= HELD;
              cnt   <= '0;
            end else begin
              state <= DEB_PRESS;
              row_c <= row_i;
              cnt   <= CW'(1);
            end
          end
          DEB_PRESS: begin
            if (!single || row_i != row_c) begin
              state <= SCAN;
              cnt   <= '0;
              kpc   <= kpc_next;
            end else if (accept) begin
              state <= HELD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (!clear) begin
              cnt <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= SCAN;
              cnt   <= '0;
              kpc   <= kpc_next;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= SCAN;
        endcase
      end
      if (accept) begin
        key_code <= code;
        case (code)
          4'hA: edit_mode <= 2'd0;
          4'hB: edit_mode <= 2'd1;
          4'hC: edit_mode <= 2'd2;
          4'hD: begin
            freqSelect     <= FREQ_RST;
            lowpassSelect  <= LP_RST;
            highpassSelect <= HP_RST;
            edit_mode      <= 2'd0;
          end
          default: begin
            if (code < 4'd8) begin
              case (edit_mode)
                2'd0:    freqSelect     <= code[2:0];
                2'd1:    lowpassSelect  <= code[2:0];
                default: highpassSelect <= code[2:0];
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule
